smem_port_arbiter: RTL and testbench

- Shares one single-port screen memory (smem) between the VGA character fetcher and the CPU load/store path.
- Sits between the memIO smem decode and the smem RAM, in the clk12 domain.
- CPU stores are posted into a small write FIFO. CPU loads and VGA fetches are reads with 1-cycle latency.
- VGA has priority, with a bounded-starvation guarantee for the CPU.

---
 rtl/smem_arb_pkg.sv | 16 +
 rtl/smem_wfifo.sv | 54 +++++
 rtl/smem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_smem_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smem_arb_pkg.sv
// Shared types and width helpers for the screen-memory port arbiter.
package smem_arb_pkg;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_VGA,
    GNT_CPU_WR,
    GNT_CPU_RD
  } grant_t;

  // Bits needed to index n items; never less than one bit.
  function automatic int clog2_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/smem_wfifo.sv
// Synchronous FIFO of posted CPU stores ({addr, data}); DEPTH must be a power of 2.
module smem_wfifo
  import smem_arb_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int PW   = clog2_width(DEPTH),
  localparam int CNTW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNTW-1:0]  count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/smem_port_arbiter.sv
// Arbitrates the single-port screen memory between VGA fetches and CPU loads/stores,
// favouring VGA but forcing a CPU slot after MAX_VGA_RUN consecutive VGA grants.
module smem_port_arbiter
  import smem_arb_pkg::*;
#(
  parameter int SMEM_SIZE   = 1200,
  parameter int NCHARS      = 64,
  parameter int WFIFO_DEPTH = 4,
  parameter int MAX_VGA_RUN = 8,
  localparam int AW   = clog2_width(SMEM_SIZE),
  localparam int CW   = clog2_width(NCHARS),
  localparam int CNTW = $clog2(WFIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            vga_req,
  input  logic [AW-1:0]   vga_addr,
  output logic            vga_gnt,
  output logic            vga_rvalid,
  output logic [CW-1:0]   vga_rdata,
  input  logic            cpu_wr,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [CW-1:0]   cpu_wdata,
  output logic            cpu_wr_ready,
  input  logic            cpu_rd_req,
  output logic            cpu_rd_valid,
  output logic [CW-1:0]   cpu_rd_data,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [CW-1:0]   mem_wdata,
  input  logic [CW-1:0]   mem_rdata,
  output logic [CNTW-1:0] wfifo_count
);

  localparam int RUNW = clog2_width(MAX_VGA_RUN + 1);

  grant_t            grant;
  logic              fifo_full;
  logic              fifo_empty;
  logic [AW+CW-1:0]  fifo_head;
  logic [AW-1:0]     head_addr;
  logic [CW-1:0]     head_data;
  logic [RUNW-1:0]   run;
  logic              rd_inflight;
  logic              vga_ret;
  logic              cpu_ret;
  logic              cpu_pend;
  logic              force_cpu;
  logic              cpu_slot;

  smem_wfifo #(
    .WIDTH (AW + CW),
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clk   (clk),
    .reset (reset),
    .push  (cpu_wr & cpu_wr_ready),
    .wdata ({cpu_addr, cpu_wdata}),
    .pop   (grant == GNT_CPU_WR),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (wfifo_count)
  );

  assign {head_addr, head_data} = fifo_head;
  assign cpu_wr_ready = ~fifo_full;
  assign cpu_pend     = ~fifo_empty | (cpu_rd_req & ~rd_inflight);
  assign force_cpu    = (run == RUNW'(MAX_VGA_RUN));
  assign cpu_slot     = cpu_pend & (force_cpu | ~vga_req);

  // Queued stores always drain before a load so a load sees every earlier store.
  always_comb begin
    grant = GNT_IDLE;
    if (cpu_slot) begin
      grant = fifo_empty ? GNT_CPU_RD : GNT_CPU_WR;
    end else if (vga_req) begin
      grant = GNT_VGA;
    end
  end

  always_comb begin
    mem_en    = (grant != GNT_IDLE);
    mem_we    = (grant == GNT_CPU_WR);
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant)
      GNT_VGA:    mem_addr = vga_addr;
      GNT_CPU_WR: begin
        mem_addr  = head_addr;
        mem_wdata = head_data;
      end
      GNT_CPU_RD: mem_addr = cpu_addr;
      default:    mem_addr = '0;
    endcase
  end

  assign vga_gnt      = (grant == GNT_VGA);
  assign vga_rvalid   = vga_ret;
  assign vga_rdata    = vga_ret ? mem_rdata : '0;
  assign cpu_rd_valid = cpu_ret;
  assign cpu_rd_data  = cpu_ret ? mem_rdata : '0;

  // Run counter only measures VGA grants that actually held CPU work back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run         <= '0;
      rd_inflight <= 1'b0;
      vga_ret     <= 1'b0;
      cpu_ret     <= 1'b0;
    end else begin
      vga_ret <= (grant == GNT_VGA);
      cpu_ret <= (grant == GNT_CPU_RD);
      if (grant == GNT_CPU_RD) begin
        rd_inflight <= 1'b1;
      end else if (cpu_ret) begin
        rd_inflight <= 1'b0;
      end
      if (cpu_slot || !cpu_pend) begin
        run <= '0;
      end else if (grant == GNT_VGA && !force_cpu) begin
        run <= run + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_smem_port_arbiter.sv
// Randomized scoreboard bench for smem_port_arbiter with a queue-based reference model.
module tb_smem_port_arbiter;

  localparam int SMEM_SIZE = 1200;
  localparam int NCHARS    = 64;
  localparam int DEPTH     = 4;
  localparam int MAX_RUN   = 8;
  localparam int AW        = $clog2(SMEM_SIZE);
  localparam int CW        = $clog2(NCHARS);
  localparam int CNTW      = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            vga_req;
  logic [AW-1:0]   vga_addr;
  logic            vga_gnt;
  logic            vga_rvalid;
  logic [CW-1:0]   vga_rdata;
  logic            cpu_wr;
  logic [AW-1:0]   cpu_addr;
  logic [CW-1:0]   cpu_wdata;
  logic            cpu_wr_ready;
  logic            cpu_rd_req;
  logic            cpu_rd_valid;
  logic [CW-1:0]   cpu_rd_data;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [CW-1:0]   mem_wdata;
  logic [CW-1:0]   mem_rdata;
  logic [CNTW-1:0] wfifo_count;

  smem_port_arbiter #(
    .SMEM_SIZE   (SMEM_SIZE),
    .NCHARS      (NCHARS),
    .WFIFO_DEPTH (DEPTH),
    .MAX_VGA_RUN (MAX_RUN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .vga_req      (vga_req),
    .vga_addr     (vga_addr),
    .vga_gnt      (vga_gnt),
    .vga_rvalid   (vga_rvalid),
    .vga_rdata    (vga_rdata),
    .cpu_wr       (cpu_wr),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_wr_ready (cpu_wr_ready),
    .cpu_rd_req   (cpu_rd_req),
    .cpu_rd_valid (cpu_rd_valid),
    .cpu_rd_data  (cpu_rd_data),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .wfifo_count  (wfifo_count)
  );

  always #5 clk = ~clk;

  // Screen RAM seen by the DUT; shadow is the model's view of the same contents.
  logic [CW-1:0] ram    [SMEM_SIZE];
  logic [CW-1:0] shadow [SMEM_SIZE];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // kind: 0 idle, 1 vga read, 2 cpu write, 3 cpu read
  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [CW-1:0] wdata;
    bit            ready;
    int            count;
    bit            vga_rv;
    bit            cpu_rv;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } store_t;

  exp_t          exp_acc[$];
  logic [CW-1:0] exp_vga[$];
  logic [CW-1:0] exp_cpu[$];
  store_t        wq[$];

  int            n_checks = 0;
  int            n_errors = 0;
  int            run_m = 0;
  int            ld_phase = 0;
  bit            vga_ret_m = 0;
  logic [AW-1:0] ld_addr_q = '0;
  bit            last_accepted;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of the reference model; called just after the rising edge.
  task automatic model_cycle(input bit v_req, input logic [AW-1:0] v_addr,
                             input bit wr_in, input logic [AW-1:0] w_addr, input logic [CW-1:0] w_data,
                             input bit ld_start, input logic [AW-1:0] ld_addr);
    exp_t   e;
    store_t s;
    bit     wr;
    bit     pend;
    wr = wr_in;
    if (ld_phase == 3) begin
      ld_phase   = 0;
      cpu_rd_req = 1'b0;
    end else if (ld_phase == 2) begin
      ld_phase = 3;
    end
    if (ld_phase != 0) wr = 1'b0;
    if (ld_start && !wr && ld_phase == 0) begin
      ld_phase   = 1;
      ld_addr_q  = ld_addr;
      cpu_rd_req = 1'b1;
    end
    vga_req   = v_req;
    vga_addr  = v_addr;
    cpu_wr    = wr;
    cpu_wdata = w_data;
    cpu_addr  = wr ? w_addr : ld_addr_q;

    e.kind   = 0;
    e.addr   = '0;
    e.wdata  = '0;
    e.count  = wq.size();
    e.ready  = (wq.size() < DEPTH);
    e.vga_rv = vga_ret_m;
    e.cpu_rv = (ld_phase == 3);
    pend     = (wq.size() != 0) || (ld_phase == 1);
    vga_ret_m = 0;

    if (pend && (run_m == MAX_RUN || !v_req)) begin
      if (wq.size() != 0) begin
        s = wq.pop_front();
        shadow[s.addr] = s.data;
        e.kind  = 2;
        e.addr  = s.addr;
        e.wdata = s.data;
      end else begin
        e.kind = 3;
        e.addr = ld_addr_q;
        exp_cpu.push_back(shadow[ld_addr_q]);
        ld_phase = 2;
      end
      run_m = 0;
    end else if (v_req) begin
      e.kind = 1;
      e.addr = v_addr;
      exp_vga.push_back(shadow[v_addr]);
      vga_ret_m = 1;
      run_m = pend ? ((run_m < MAX_RUN) ? run_m + 1 : MAX_RUN) : 0;
    end else begin
      run_m = 0;
    end

    last_accepted = wr && e.ready;
    if (last_accepted) begin
      s.addr = w_addr;
      s.data = w_data;
      wq.push_back(s);
    end
    exp_acc.push_back(e);
  endtask

  task automatic applyStimulus(input bit v_req, input logic [AW-1:0] v_addr,
                               input bit wr, input logic [AW-1:0] w_addr, input logic [CW-1:0] w_data,
                               input bit ld_start, input logic [AW-1:0] ld_addr);
    @(posedge clk);
    #1;
    model_cycle(v_req, v_addr, wr, w_addr, w_data, ld_start, ld_addr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, '0, '0, 0, '0);
  endtask

  // Reset asserted mid-cycle; all queued and in-flight work must vanish.
  task automatic doReset();
    @(posedge clk);
    #3;
    reset      = 1'b0;
    vga_req    = 1'b0;
    vga_addr   = '0;
    cpu_wr     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    cpu_rd_req = 1'b0;
    exp_acc.delete();
    exp_vga.delete();
    exp_cpu.delete();
    wq.delete();
    run_m     = 0;
    ld_phase  = 0;
    vga_ret_m = 0;
    #1;
    checkOutput("rst_count", 32'(wfifo_count), 32'd0);
    checkOutput("rst_ready", 32'(cpu_wr_ready), 32'd1);
    checkOutput("rst_ctrl", {27'd0, mem_en, mem_we, vga_gnt, vga_rvalid, cpu_rd_valid}, 32'd0);
    checkOutput("rst_data", {20'd0, vga_rdata, cpu_rd_data}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_cycle(0, '0, 0, '0, '0, 0, '0);
  endtask

  exp_t          mon_e;
  logic [2:0]    mon_ctl;
  logic [CW-1:0] mon_d;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (exp_acc.size() != 0) begin
        mon_e = exp_acc.pop_front();
        case (mon_e.kind)
          1:       mon_ctl = 3'b101;
          2:       mon_ctl = 3'b110;
          3:       mon_ctl = 3'b100;
          default: mon_ctl = 3'b000;
        endcase
        checkOutput("grant", {29'd0, mem_en, mem_we, vga_gnt}, {29'd0, mon_ctl});
        if (mon_e.kind != 0) checkOutput("mem_addr", 32'(mem_addr), 32'(mon_e.addr));
        if (mon_e.kind == 2) checkOutput("mem_wdata", 32'(mem_wdata), 32'(mon_e.wdata));
        checkOutput("wfifo", {28'd0, cpu_wr_ready, wfifo_count},
                    {28'd0, mon_e.ready, CNTW'(mon_e.count)});
        checkOutput("rvalid", {30'd0, vga_rvalid, cpu_rd_valid},
                    {30'd0, mon_e.vga_rv, mon_e.cpu_rv});
      end
      if (vga_rvalid) begin
        if (exp_vga.size() == 0) begin
          checkOutput("vga_unexpected", 32'(vga_rvalid), 32'd0);
        end else begin
          mon_d = exp_vga.pop_front();
          checkOutput("vga_rdata", 32'(vga_rdata), 32'(mon_d));
        end
      end
      if (cpu_rd_valid) begin
        if (exp_cpu.size() == 0) begin
          checkOutput("cpu_unexpected", 32'(cpu_rd_valid), 32'd0);
        end else begin
          mon_d = exp_cpu.pop_front();
          checkOutput("cpu_rd_data", 32'(cpu_rd_data), 32'(mon_d));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int vga_pct;
    bit vr;
    bit wr;
    bit ld;
    reset      = 1'b0;
    vga_req    = 1'b0;
    vga_addr   = '0;
    cpu_wr     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    cpu_rd_req = 1'b0;
    mem_rdata  = '0;
    for (int i = 0; i < SMEM_SIZE; i++) begin
      ram[i]    = CW'($urandom);
      shadow[i] = ram[i];
    end
    doReset();

    $display("[TB] reset with stores queued");
    applyStimulus(1, 11'd1, 1, 11'd300, 6'h15, 0, '0);
    applyStimulus(1, 11'd2, 1, 11'd301, 6'h16, 0, '0);
    applyStimulus(1, 11'd3, 0, '0, '0, 0, '0);
    doReset();
    idle(12);

    $display("[TB] vga only");
    for (int a = 5; a <= 7; a++) applyStimulus(1, AW'(a), 0, '0, '0, 0, '0);
    idle(2);

    $display("[TB] starvation bound");
    applyStimulus(1, 11'd20, 1, 11'd100, 6'h2A, 0, '0);
    for (int i = 0; i < 14; i++) applyStimulus(1, AW'(21 + i), 0, '0, '0, 0, '0);
    idle(2);

    $display("[TB] read after write");
    applyStimulus(0, '0, 1, 11'd40, 6'h11, 0, '0);
    applyStimulus(0, '0, 0, '0, '0, 1, 11'd40);
    idle(4);

    $display("[TB] fifo full");
    for (int i = 0; i < 4; i++) applyStimulus(1, AW'(i), 1, AW'(200 + i), CW'(i + 1), 0, '0);
    last_accepted = 0;
    for (int i = 0; i < 30 && !last_accepted; i++)
      applyStimulus(1, AW'(50 + i), 1, 11'd204, 6'h05, 0, '0);
    for (int i = 0; i < 30; i++) applyStimulus(1, AW'(80 + i), 0, '0, '0, 0, '0);
    idle(8);

    $display("[TB] single load");
    applyStimulus(0, '0, 0, '0, '0, 1, 11'd300);
    idle(3);

    $display("[TB] random traffic");
    vga_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      if (i % 250 == 0) begin
        case ((i / 250) % 4)
          0:       vga_pct = 70;
          1:       vga_pct = 100;
          2:       vga_pct = 20;
          default: vga_pct = 90;
        endcase
      end
      if (i == 777) doReset();
      vr = ($urandom_range(0, 99) < vga_pct);
      ld = ($urandom_range(0, 9) == 0);
      wr = !ld && ($urandom_range(0, 99) < 35);
      applyStimulus(vr, AW'($urandom_range(0, SMEM_SIZE - 1)),
                    wr, AW'($urandom_range(0, SMEM_SIZE - 1)), CW'($urandom),
                    ld, AW'($urandom_range(0, SMEM_SIZE - 1)));
    end
    idle(20);
    @(negedge clk);
    #1;
    checkOutput("vga_queue_drained", 32'(exp_vga.size()), 32'd0);
    checkOutput("cpu_queue_drained", 32'(exp_cpu.size()), 32'd0);
    checkOutput("wfifo_drained", 32'(wfifo_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
